mobo_xfer: RTL and testbench
============================

MOBO_XFER -- requirements
Module: mobo_xfer

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of address and data words.
REQ-002 Parameter LEN_W, default 4, width of the burst-length field (bursts of 0..2^LEN_W-1 words).
REQ-003 Parameter TIMEOUT, default 255, maximum wait cycles per bus phase before abort.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1 / req_ready  out  1  transfer request handshake.
REQ-007 req_write  in  1  1 = write burst, 0 = read burst; sampled on request accept.
REQ-008 req_addr  in  WORD_WIDTH / req_len  in  LEN_W  start address and word count.
REQ-009 wr_valid  in  1 / wr_ready  out  1 / wr_data  in  WORD_WIDTH  write-data pull handshake.
REQ-010 rd_valid  out  1 / rd_ready  in  1 / rd_data  out  WORD_WIDTH  read-data push handshake.
REQ-011 done  out  1 / err  out  1  one-cycle completion pulse; err qualifies done.
REQ-012 mobo_ctrl  out  WORD_WIDTH  bus command, one of CTRL_NONE, CTRL_WRITE, CTRL_READ.
REQ-013 mobo_stat  in  WORD_WIDTH  bus status, STAT_IDLE or STAT_DONE.
REQ-014 addr_out, mobodat_out  out  WORD_WIDTH / mobodat_in  in  WORD_WIDTH  bus address and data.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, WAIT_IDLE, WAIT_DONE, PUSH, FINISH.
REQ-016 req_ready SHALL be 1 only in IDLE; accept on req_valid&&req_ready latches write, address, length.
REQ-017 An accepted request with req_len==0 SHALL go to FINISH with no bus command issued.
REQ-018 A write word SHALL start in FETCH with wr_ready=1; on wr_valid the data is latched into mobodat_out and the FSM enters WAIT_IDLE.
REQ-019 A read word SHALL start directly in WAIT_IDLE.
REQ-020 In WAIT_IDLE, on mobo_stat==STAT_IDLE, mobo_ctrl SHALL be registered to CTRL_WRITE or CTRL_READ on the next edge and the FSM enters WAIT_DONE.
REQ-021 addr_out and mobodat_out SHALL be stable from one cycle before command assertion until CTRL_NONE is restored.
REQ-022 In WAIT_DONE, on mobo_stat==STAT_DONE, mobo_ctrl SHALL return to CTRL_NONE next edge and, for reads, mobodat_in is captured into rd_data.
REQ-023 After a read word the FSM SHALL enter PUSH, holding rd_valid=1 and rd_data stable until rd_ready.
REQ-024 After each word the remaining count SHALL decrement and addr_out increment by 1, wrapping modulo 2^WORD_WIDTH.
REQ-025 When the remaining count reaches 0 the FSM SHALL enter FINISH, pulse done for one cycle, and return to IDLE.
REQ-026 No new command SHALL issue until mobo_stat has returned to STAT_IDLE after the prior STAT_DONE.
REQ-027 mobo_ctrl SHALL only change in IDLE/WAIT_IDLE/WAIT_DONE transitions, never glitch combinationally.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, mobo_ctrl=CTRL_NONE, addr_out=0, mobodat_out=0, rd_data=0, all handshake outputs, done and err to 0.
REQ-029 Reset mid-burst SHALL abandon the burst with no done pulse; the first accept after release starts clean.

Configuration
REQ-030 With MOBO_XFER_TIMEOUT_EN defined, a counter SHALL count cycles in WAIT_IDLE and WAIT_DONE; reaching TIMEOUT forces mobo_ctrl=CTRL_NONE, pulses done and err together, drops remaining words, and returns to IDLE.
REQ-031 Without MOBO_XFER_TIMEOUT_EN, waits SHALL be unbounded and err SHALL be tied to 0.

Verification
REQ-032 Write len=1, addr=0x3, data=0x5, bus answers IDLE then DONE after 2 cycles -> one CTRL_WRITE, addr_out=0x3, mobodat_out=0x5, done=1, err=0.
REQ-033 Read len=4, addr=0xFFFFFFFE, mobodat_in=0xA0..0xA3 -> addresses FFFFFFFE,FFFFFFFF,0,1; rd_data sequence A0..A3; one done.
REQ-034 Read len=2 with rd_ready low 5 cycles -> rd_valid held, rd_data stable, second command not issued until pop.
REQ-035 req_len=0 -> done pulse within 2 cycles, mobo_ctrl stays CTRL_NONE.
REQ-036 Timeout enabled, TIMEOUT=8, mobo_stat never DONE -> mobo_ctrl CTRL_NONE after 8 cycles, done=err=1 one cycle.
REQ-037 rst low during WAIT_DONE of a 3-word write -> immediate CTRL_NONE, no done; next request completes normally.

Source files
------------

// File: rtl/mobo_xfer.sv
// Burst transfer engine: moves words between req/wr/rd handshakes and a command/status bus.
// Define MOBO_XFER_TIMEOUT_EN to bound each bus wait phase to TIMEOUT cycles (abort with err).
module mobo_xfer #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [WORD_WIDTH-1:0] i_req_addr,
    input  logic [LEN_W-1:0]      i_req_len,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [WORD_WIDTH-1:0] o_rd_data,
    output logic                  o_done,
    output logic                  o_err,
    output logic [WORD_WIDTH-1:0] o_mobo_ctrl,
    input  logic [WORD_WIDTH-1:0] i_mobo_stat,
    output logic [WORD_WIDTH-1:0] o_addr_out,
    output logic [WORD_WIDTH-1:0] o_mobodat_out,
    input  logic [WORD_WIDTH-1:0] i_mobodat_in
);
    localparam logic [WORD_WIDTH-1:0] CTRL_NONE  = WORD_WIDTH'(0);
    localparam logic [WORD_WIDTH-1:0] CTRL_WRITE = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] CTRL_READ  = WORD_WIDTH'(2);
    localparam logic [WORD_WIDTH-1:0] STAT_IDLE  = WORD_WIDTH'(0);
    localparam logic [WORD_WIDTH-1:0] STAT_DONE  = WORD_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_IDLE,
        WAIT_DONE,
        PUSH,
        FINISH
    } state_t;

    state_t                r_state, w_state_d;
    logic                  r_write, w_write_d;
    logic [WORD_WIDTH-1:0] r_addr, w_addr_d;
    logic [WORD_WIDTH-1:0] r_wdata, w_wdata_d;
    logic [WORD_WIDTH-1:0] r_rdata, w_rdata_d;
    logic [LEN_W-1:0]      r_remain, w_remain_d;
    logic [WORD_WIDTH-1:0] r_ctrl, w_ctrl_d;
    logic                  r_req_ready, r_wr_ready, r_rd_valid, r_done;
    logic                  w_advance;

`ifdef MOBO_XFER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    logic             w_abort;
    logic             w_waiting;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_write_d  = r_write;
        w_addr_d   = r_addr;
        w_wdata_d  = r_wdata;
        w_rdata_d  = r_rdata;
        w_remain_d = r_remain;
        w_ctrl_d   = r_ctrl;
        w_advance  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_write_d  = i_req_write;
                    w_addr_d   = i_req_addr;
                    w_remain_d = i_req_len;
                    if (i_req_len == '0) begin
                        w_state_d = FINISH;
                    end else if (i_req_write) begin
                        w_state_d = FETCH;
                    end else begin
                        w_state_d = WAIT_IDLE;
                    end
                end
            end
            FETCH: begin
                if (i_wr_valid) begin
                    w_wdata_d = i_wr_data;
                    w_state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (i_mobo_stat == STAT_IDLE) begin
                    w_ctrl_d  = r_write ? CTRL_WRITE : CTRL_READ;
                    w_state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_mobo_stat == STAT_DONE) begin
                    w_ctrl_d = CTRL_NONE;
                    if (r_write) begin
                        w_advance = 1'b1;
                    end else begin
                        w_rdata_d = i_mobodat_in;
                        w_state_d = PUSH;
                    end
                end
            end
            PUSH: begin
                if (i_rd_ready) begin
                    w_advance = 1'b1;
                end
            end
            FINISH: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // A completed word moves the address on and picks the next phase.
        if (w_advance) begin
            w_remain_d = r_remain - LEN_W'(1);
            w_addr_d   = r_addr + WORD_WIDTH'(1);
            if (r_remain == LEN_W'(1)) begin
                w_state_d = FINISH;
            end else if (r_write) begin
                w_state_d = FETCH;
            end else begin
                w_state_d = WAIT_IDLE;
            end
        end

`ifdef MOBO_XFER_TIMEOUT_EN
        w_waiting = (r_state == WAIT_IDLE) || (r_state == WAIT_DONE);
        w_abort   = w_waiting && (w_state_d == r_state) && (r_tmo == TMO_W'(TIMEOUT - 1));
        if (w_abort) begin
            w_ctrl_d  = CTRL_NONE;
            w_state_d = FINISH;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_remain    <= '0;
            r_ctrl      <= CTRL_NONE;
            r_req_ready <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_write     <= w_write_d;
            r_addr      <= w_addr_d;
            r_wdata     <= w_wdata_d;
            r_rdata     <= w_rdata_d;
            r_remain    <= w_remain_d;
            r_ctrl      <= w_ctrl_d;
            // Handshake flags are decoded from the next state so they stay glitch-free.
            r_req_ready <= (w_state_d == IDLE);
            r_wr_ready  <= (w_state_d == FETCH);
            r_rd_valid  <= (w_state_d == PUSH);
            r_done      <= (w_state_d == FINISH);
        end
    end

`ifdef MOBO_XFER_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (w_state_d != r_state) begin
                r_tmo <= '0;
            end else if (w_waiting) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_req_ready   = r_req_ready;
    assign o_wr_ready    = r_wr_ready;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rdata;
    assign o_done        = r_done;
    assign o_mobo_ctrl   = r_ctrl;
    assign o_addr_out    = r_addr;
    assign o_mobodat_out = r_wdata;

endmodule

// File: tb/tb_mobo_xfer.sv
// Randomized bench for mobo_xfer: a bus responder plus a transaction-level expectation model.
module tb_mobo_xfer;
    localparam int          TMO        = 8;
    localparam logic [31:0] CTRL_NONE  = 32'd0;
    localparam logic [31:0] CTRL_WRITE = 32'd1;
    localparam logic [31:0] CTRL_READ  = 32'd2;
    localparam logic [31:0] STAT_IDLE  = 32'd0;
    localparam logic [31:0] STAT_DONE  = 32'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        done, err;
    logic [31:0] mobo_ctrl, mobo_stat, addr_out, mobodat_out, mobodat_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus responder state and observed command log.
    bit          bus_hold = 1'b0;
    int          done_cnt = 0;
    logic [31:0] cmd_ctrl_q[$];
    logic [31:0] cmd_addr_q[$];
    logic [31:0] cmd_dat_q[$];
    logic [31:0] rd_src_q[$];
    logic [31:0] wr_src_q[$];

    mobo_xfer #(
        .WORD_WIDTH (32),
        .LEN_W      (4),
        .TIMEOUT    (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_len     (req_len),
        .i_wr_valid    (wr_valid),
        .o_wr_ready    (wr_ready),
        .i_wr_data     (wr_data),
        .o_rd_valid    (rd_valid),
        .i_rd_ready    (rd_ready),
        .o_rd_data     (rd_data),
        .o_done        (done),
        .o_err         (err),
        .o_mobo_ctrl   (mobo_ctrl),
        .i_mobo_stat   (mobo_stat),
        .o_addr_out    (addr_out),
        .o_mobodat_out (mobodat_out),
        .i_mobodat_in  (mobodat_in)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Responder: answers commands with DONE after a short random delay, then returns to IDLE.
    initial begin : responder
        logic [31:0] prev_ctrl, prev_addr, prev_dat, hold_addr, hold_dat;
        int          wait_cnt, idle_cnt;
        mobo_stat  = STAT_IDLE;
        mobodat_in = '0;
        prev_ctrl  = CTRL_NONE;
        prev_addr  = '0;
        prev_dat   = '0;
        hold_addr  = '0;
        hold_dat   = '0;
        wait_cnt   = 0;
        idle_cnt   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mobo_stat = STAT_IDLE;
                prev_ctrl = CTRL_NONE;
                prev_addr = '0;
                prev_dat  = '0;
            end else begin
                if (done) done_cnt++;
                if (mobo_stat == STAT_DONE) check_eq("ctrl_release", mobo_ctrl, CTRL_NONE);
                if (mobo_ctrl != CTRL_NONE && prev_ctrl == CTRL_NONE) begin
                    check_eq("cmd_after_idle", mobo_stat, STAT_IDLE);
                    check_eq("addr_pre", addr_out, prev_addr);
                    check_eq("dat_pre", mobodat_out, prev_dat);
                    cmd_ctrl_q.push_back(mobo_ctrl);
                    cmd_addr_q.push_back(addr_out);
                    cmd_dat_q.push_back(mobodat_out);
                    hold_addr = addr_out;
                    hold_dat  = mobodat_out;
                    wait_cnt  = $urandom_range(4, 0);
                end else if (mobo_ctrl != CTRL_NONE) begin
                    check_eq("addr_stable", addr_out, hold_addr);
                    check_eq("dat_stable", mobodat_out, hold_dat);
                end
                if (mobo_ctrl != CTRL_NONE && mobo_stat == STAT_IDLE && !bus_hold) begin
                    if (wait_cnt == 0) begin
                        mobo_stat  = STAT_DONE;
                        mobodat_in = (rd_src_q.size() > 0) ? rd_src_q.pop_front()
                                                           : mem_f(addr_out);
                        idle_cnt   = $urandom_range(2, 0);
                    end else begin
                        wait_cnt--;
                    end
                end else if (mobo_stat == STAT_DONE && mobo_ctrl == CTRL_NONE) begin
                    if (idle_cnt == 0) mobo_stat = STAT_IDLE;
                    else idle_cnt--;
                end
                prev_ctrl = mobo_ctrl;
                prev_addr = addr_out;
                prev_dat  = mobodat_out;
            end
        end
    end

    task automatic send_req(input bit wr, input logic [31:0] a, input int len);
        int cyc;
        tick();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_len   = 4'(len);
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check_eq("req_ready_wait", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // One burst: expected commands, write data and read data come from the request alone.
    task automatic do_xfer(input bit wr, input logic [31:0] a, input int len, input int stall);
        logic [31:0] wq[$];
        logic [31:0] erd[$];
        logic [31:0] held;
        int          widx, ridx, cyc, d0, stall_cnt, ncmp;
        bit          done_seen, have_held, go;
        cmd_ctrl_q.delete();
        cmd_addr_q.delete();
        cmd_dat_q.delete();
        for (int i = 0; i < len; i++) begin
            wq.push_back((i < wr_src_q.size()) ? wr_src_q[i] : $urandom);
            erd.push_back((i < rd_src_q.size()) ? rd_src_q[i] : mem_f(a + 32'(i)));
        end
        wr_src_q.delete();
        if (wr) rd_src_q.delete();
        d0 = done_cnt;
        widx = 0; ridx = 0; stall_cnt = 0; held = '0;
        done_seen = 1'b0; have_held = 1'b0;
        send_req(wr, a, len);
        cyc = 0;
        while (!done_seen && cyc < 2000) begin
            if (done) begin
                done_seen = 1'b1;
                check_eq("err_clear", {31'd0, err}, 32'd0);
                if (len == 0) check_eq("len0_latency", {31'd0, cyc <= 1}, 32'd1);
            end
            wr_data  = (widx < len) ? wq[widx] : '0;
            wr_valid = (widx < len) && ($urandom_range(3, 0) != 0);
            if (wr_ready && wr_valid) widx++;
            if (have_held) check_eq("rd_valid_held", {31'd0, rd_valid}, 32'd1);
            if (rd_valid) begin
                if (have_held) check_eq("rd_data_held", rd_data, held);
                check_eq("cmd_gated_by_pop", 32'(cmd_ctrl_q.size()), 32'(ridx + 1));
                held      = rd_data;
                have_held = 1'b1;
                go        = (stall < 0) ? 1'($urandom_range(1, 0)) : (stall_cnt >= stall);
                rd_ready  = go;
                stall_cnt++;
                if (go) begin
                    check_eq("rd_data", rd_data, (ridx < len) ? erd[ridx] : 32'hDEAD_BEEF);
                    ridx++;
                    have_held = 1'b0;
                    stall_cnt = 0;
                end
            end else begin
                rd_ready = 1'($urandom_range(1, 0));
            end
            tick();
            cyc++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check_eq("done_seen", {31'd0, done_seen}, 32'd1);
        check_eq("done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("cmd_count", 32'(cmd_ctrl_q.size()), 32'(len));
        check_eq("wr_words", 32'(widx), wr ? 32'(len) : 32'd0);
        check_eq("rd_words", 32'(ridx), wr ? 32'd0 : 32'(len));
        ncmp = (cmd_ctrl_q.size() < len) ? cmd_ctrl_q.size() : len;
        for (int i = 0; i < ncmp; i++) begin
            check_eq("cmd_ctrl", cmd_ctrl_q[i], wr ? CTRL_WRITE : CTRL_READ);
            check_eq("cmd_addr", cmd_addr_q[i], a + 32'(i));
            if (wr) check_eq("cmd_wdata", cmd_dat_q[i], wq[i]);
        end
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        check_eq("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          cyc, d0, n;
        logic [31:0] a;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        tick();
        tick();
        check_eq("rst_ctrl", mobo_ctrl, CTRL_NONE);
        check_eq("rst_addr", addr_out, 32'd0);
        check_eq("rst_flags", {27'd0, req_ready, wr_ready, rd_valid, done, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("idle_ready", {31'd0, req_ready}, 32'd1);

        wr_src_q = '{32'h5};
        do_xfer(1'b1, 32'h3, 1, -1);

        rd_src_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_xfer(1'b0, 32'hFFFF_FFFE, 4, -1);

        do_xfer(1'b0, 32'h0000_1000, 2, 5);
        do_xfer(1'b0, 32'h0000_0000, 0, -1);
        do_xfer(1'b1, 32'h0000_0000, 0, -1);
        do_xfer(1'b1, 32'hFFFF_FFF8, 15, 2);

        for (int t = 0; t < 20; t++) begin
            a = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0))
                                             : $urandom;
            do_xfer(1'($urandom_range(1, 0)), a, $urandom_range(15, 0), -1);
        end

        // Reset while a 3-word write is waiting for DONE.
        bus_hold = 1'b1;
        d0 = done_cnt;
        cmd_ctrl_q.delete();
        wr_valid = 1'b1;
        wr_data  = 32'h77;
        send_req(1'b1, 32'h100, 3);
        cyc = 0;
        while (mobo_ctrl == CTRL_NONE && cyc < 50) begin
            tick();
            cyc++;
        end
        check_eq("rst_cmd_seen", mobo_ctrl, CTRL_WRITE);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ctrl", mobo_ctrl, CTRL_NONE);
        check_eq("rst_mid_addr", addr_out, 32'd0);
        check_eq("rst_mid_dat", mobodat_out, 32'd0);
        check_eq("rst_mid_rdat", rd_data, 32'd0);
        check_eq("rst_mid_flags", {27'd0, req_ready, wr_ready, rd_valid, done, err}, 32'd0);
        wr_valid = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        bus_hold = 1'b0;
        tick();
        tick();
        check_eq("rst_no_done", 32'(done_cnt - d0), 32'd0);
        do_xfer(1'b1, 32'h200, 3, -1);

`ifdef MOBO_XFER_TIMEOUT_EN
        // Bus never answers DONE: the command must be withdrawn after TMO cycles.
        bus_hold = 1'b1;
        cmd_ctrl_q.delete();
        send_req(1'b0, 32'h40, 2);
        cyc = 0;
        while (mobo_ctrl == CTRL_NONE && cyc < 50) begin
            tick();
            cyc++;
        end
        n = 0;
        while (mobo_ctrl != CTRL_NONE && n < 100) begin
            n++;
            tick();
        end
        check_eq("tmo_cycles", 32'(n), 32'(TMO));
        check_eq("tmo_done_err", {30'd0, done, err}, 32'd3);
        tick();
        check_eq("tmo_pulse", {30'd0, done, err}, 32'd0);
        check_eq("tmo_cmds", 32'(cmd_ctrl_q.size()), 32'd1);
        bus_hold = 1'b0;
        tick();
        tick();
        do_xfer(1'b0, 32'h80, 3, -1);
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
